// File: rtl/multdiv_seq.sv
// multdiv_seq -- iterative signed 32-bit multiplier / divider.
//
// The unit does one operation at a time. Each operation takes 32 iterations,
// one per clock, for every operand value, so start-to-result latency is fixed.
//   Multiply: shift-add on operand magnitudes. The sign is applied to the
//             64-bit product. The result is the low word. exception flags a
//             product that does not fit in 32 signed bits.
//   Divide:   restoring division on magnitudes. The quotient truncates toward
//             zero. exception flags divide-by-zero (result forced to 0) and
//             0x80000000 / -1 (result 0x80000000).
//
// Handshake: a start is accepted only in IDLE. busy rises on the accepting
// edge and stays high through the DONE cycle. result_rdy is a one-cycle pulse.
// result/exception are valid during that pulse and hold until the next
// operation completes or clr is asserted. Starts seen while busy are dropped.
// If both starts are high in IDLE, the multiply wins.
//
// Ports:
//   clk         clock, rising edge
//   clr         asynchronous active-high reset
//   start_mult  request op_a * op_b
//   start_div   request op_a / op_b
//   op_a, op_b  32-bit two's-complement operands, latched at the accepted start
//   result      product low word or quotient (registered)
//   exception   overflow / divide-by-zero flag (registered)
//   result_rdy  one-cycle completion pulse
//   busy        operation in progress, including the DONE cycle
module multdiv_seq (
    input  logic        clk,
    input  logic        clr,
    input  logic        start_mult,
    input  logic        start_div,
    input  logic [31:0] op_a,
    input  logic [31:0] op_b,
    output logic [31:0] result,
    output logic        exception,
    output logic        result_rdy,
    output logic        busy
);

    typedef enum logic [1:0] {IDLE, MULT, DIV, DONE} state_t;

    state_t      state;
    logic [4:0]  cnt;
    logic [31:0] hi;        // multiply: upper partial product; divide: remainder
    logic [31:0] lo;        // multiply: multiplier/low product; divide: dividend/quotient
    logic [31:0] mag_b;     // |op_b|: multiplicand or divisor
    logic        neg;       // sign of the final result
    logic        div_zero;
    logic        div_ovf;

    logic [32:0] m_sum;
    logic [31:0] m_hi_n;
    logic [31:0] m_lo_n;
    logic [31:0] d_shift;
    logic [32:0] d_diff;
    logic [31:0] d_hi_n;
    logic [31:0] d_lo_n;
    logic [63:0] prod_s;
    logic        m_exc;
    logic [31:0] quo_s;

    always_comb begin
        // One shift-add step: add the multiplicand when the current multiplier
        // bit is set, then shift the 65-bit {carry, hi, lo} right by one.
        m_sum  = {1'b0, hi} + (lo[0] ? {1'b0, mag_b} : 33'd0);
        m_hi_n = m_sum[32:1];
        m_lo_n = {m_sum[0], lo[31:1]};

        // One restoring step. The remainder is always below the divisor
        // (<= 2^31), so its top bit is zero and the shifted value fits in 32 bits.
        d_shift = {hi[30:0], lo[31]};
        d_diff  = {1'b0, d_shift} - {1'b0, mag_b};
        if (!d_diff[32]) begin
            d_hi_n = d_diff[31:0];
            d_lo_n = {lo[30:0], 1'b1};
        end else begin
            d_hi_n = d_shift;
            d_lo_n = {lo[30:0], 1'b0};
        end

        // Final values, used only on the last iteration.
        prod_s = neg ? -{m_hi_n, m_lo_n} : {m_hi_n, m_lo_n};
        m_exc  = !((&prod_s[63:31]) || !(|prod_s[63:31]));
        quo_s  = neg ? -d_lo_n : d_lo_n;
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state      <= IDLE;
            cnt        <= 5'd0;
            hi         <= 32'd0;
            lo         <= 32'd0;
            mag_b      <= 32'd0;
            neg        <= 1'b0;
            div_zero   <= 1'b0;
            div_ovf    <= 1'b0;
            result     <= 32'd0;
            exception  <= 1'b0;
            result_rdy <= 1'b0;
            busy       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start_mult || start_div) begin
                        hi       <= 32'd0;
                        lo       <= op_a[31] ? (~op_a + 32'd1) : op_a;
                        mag_b    <= op_b[31] ? (~op_b + 32'd1) : op_b;
                        neg      <= op_a[31] ^ op_b[31];
                        div_zero <= (op_b == 32'd0);
                        div_ovf  <= (op_a == 32'h8000_0000) && (op_b == 32'hFFFF_FFFF);
                        cnt      <= 5'd0;
                        busy     <= 1'b1;
                        state    <= start_mult ? MULT : DIV;
                    end
                end
                MULT: begin
                    hi  <= m_hi_n;
                    lo  <= m_lo_n;
                    cnt <= cnt + 5'd1;
                    if (cnt == 5'd31) begin
                        state      <= DONE;
                        result     <= prod_s[31:0];
                        exception  <= m_exc;
                        result_rdy <= 1'b1;
                    end
                end
                DIV: begin
                    hi  <= d_hi_n;
                    lo  <= d_lo_n;
                    cnt <= cnt + 5'd1;
                    if (cnt == 5'd31) begin
                        state      <= DONE;
                        result     <= div_zero ? 32'd0 : quo_s;
                        exception  <= div_zero | div_ovf;
                        result_rdy <= 1'b1;
                    end
                end
                DONE: begin
                    result_rdy <= 1'b0;
                    busy       <= 1'b0;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_multdiv_seq.sv
module tb_multdiv_seq;

    logic        clk;
    logic        clr;
    logic        start_mult;
    logic        start_div;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic [31:0] result;
    logic        exception;
    logic        result_rdy;
    logic        busy;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    logic [32:0] exp_q[$];    // {exception, result}
    int          start_q[$];  // cycle number of the accepting edge

    multdiv_seq dut (
        .clk        (clk),
        .clr        (clr),
        .start_mult (start_mult),
        .start_div  (start_div),
        .op_a       (op_a),
        .op_b       (op_b),
        .result     (result),
        .exception  (exception),
        .result_rdy (result_rdy),
        .busy       (busy)
    );

    // clock / cycle counter
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
        end
    endtask

    // monitor / scoreboard
    always @(negedge clk) begin
        if (result_rdy === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_rdy: result_rdy at cycle %0d with nothing expected", cyc);
            end else begin
                logic [32:0] e;
                int          s;
                e = exp_q.pop_front();
                s = start_q.pop_front();
                check("result", {32'd0, result}, {32'd0, e[31:0]});
                check("exception", {63'd0, exception}, {63'd0, e[32]});
                check("latency", 64'(cyc - s), 64'd32);
                check("busy_in_done", {63'd0, busy}, 64'd1);
            end
        end
    end

    // driver: present one request for one edge, optionally expecting a result
    task automatic issue(input logic m, input logic d, input logic [31:0] a, input logic [31:0] b,
                         input logic expect_it, input logic [31:0] er, input logic ee);
        @(negedge clk);
        start_mult = m;
        start_div  = d;
        op_a       = a;
        op_b       = b;
        if (expect_it) begin
            exp_q.push_back({ee, er});
            start_q.push_back(cyc + 1);
        end
        @(negedge clk);
        start_mult = 1'b0;
        start_div  = 1'b0;
        check("busy_after_start", {63'd0, busy}, 64'd1);
    endtask

    // wait for the operation to finish; noise scrambles operands and pulses
    // start_div while busy and during DONE
    task automatic wait_done(input logic noise);
        int n = 0;
        int guard = 0;
        while (busy === 1'b1 && guard < 40) begin
            n++;
            if (noise) begin
                op_a      = $urandom;
                op_b      = $urandom;
                start_div = (n == 5) || (result_rdy === 1'b1);
            end
            @(negedge clk);
            guard++;
        end
        start_div = 1'b0;
        if (guard >= 40) begin
            checks++;
            errors++;
            $display("FAIL timeout: busy still high after %0d cycles", guard);
        end else begin
            check("busy_cycles", 64'(n), 64'd33);
        end
        if (noise) begin
            @(negedge clk);
            check("no_restart", {63'd0, busy}, 64'd0);
        end
    endtask

    task automatic op(input logic m, input logic d, input logic [31:0] a, input logic [31:0] b,
                      input logic [31:0] er, input logic ee);
        issue(m, d, a, b, 1'b1, er, ee);
        wait_done(1'b0);
    endtask

    initial begin
        clr        = 1'b1;
        start_mult = 1'b0;
        start_div  = 1'b0;
        op_a       = 32'd0;
        op_b       = 32'd0;
        #3;
        check("rst_result", {32'd0, result}, 64'd0);
        check("rst_exception", {63'd0, exception}, 64'd0);
        check("rst_rdy", {63'd0, result_rdy}, 64'd0);
        check("rst_busy", {63'd0, busy}, 64'd0);
        @(negedge clk);
        clr = 1'b0;

        // multiply
        op(1, 0, 32'd7,          32'hFFFF_FFFA, 32'hFFFF_FFD6, 1'b0);
        op(1, 0, 32'h0001_0000,  32'h0001_0000, 32'h0000_0000, 1'b1);
        op(1, 0, 32'h4000_0000,  32'd2,         32'h8000_0000, 1'b1);
        op(1, 0, 32'hFFFF_0000,  32'h0000_8000, 32'h8000_0000, 1'b0);
        op(1, 0, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'h0000_0001, 1'b0);
        op(1, 0, 32'h7FFF_FFFF,  32'h7FFF_FFFF, 32'h0000_0001, 1'b1);
        op(1, 0, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 1'b1);
        op(1, 0, 32'd0,          32'h1234_5678, 32'h0000_0000, 1'b0);

        // divide
        op(0, 1, 32'hFFFF_FF9C,  32'd7,         32'hFFFF_FFF2, 1'b0);
        op(0, 1, 32'd100,        32'hFFFF_FFF9, 32'hFFFF_FFF2, 1'b0);
        op(0, 1, 32'hFFFF_FF9C,  32'hFFFF_FFF9, 32'h0000_000E, 1'b0);
        op(0, 1, 32'd5,          32'd0,         32'h0000_0000, 1'b1);
        op(0, 1, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 1'b1);
        op(0, 1, 32'h8000_0000,  32'd2,         32'hC000_0000, 1'b0);
        op(0, 1, 32'h7FFF_FFFF,  32'h7FFF_FFFF, 32'h0000_0001, 1'b0);
        op(0, 1, 32'd7,          32'h8000_0000, 32'h0000_0000, 1'b0);
        op(0, 1, 32'd1000,       32'd10,        32'h0000_0064, 1'b0);

        // clr in the middle of a divide: no pulse, result back to 0
        issue(0, 1, 32'd1000, 32'd3, 1'b0, 32'd0, 1'b0);
        repeat (9) @(negedge clk);
        #2 clr = 1'b1;
        #1;
        check("abort_busy", {63'd0, busy}, 64'd0);
        check("abort_result", {32'd0, result}, 64'd0);
        check("abort_rdy", {63'd0, result_rdy}, 64'd0);
        @(negedge clk);
        clr = 1'b0;
        repeat (40) @(negedge clk);
        check("abort_idle", {63'd0, busy}, 64'd0);
        op(1, 0, 32'd3, 32'd4, 32'd12, 1'b0);

        // both starts: multiply wins; noise on operands and start_div ignored
        issue(1, 1, 32'd6, 32'd3, 1'b1, 32'd18, 1'b0);
        wait_done(1'b1);

        // start held high: second request accepted at E34 with new operands
        @(negedge clk);
        start_mult = 1'b1;
        op_a       = 32'd3;
        op_b       = 32'd5;
        exp_q.push_back({1'b0, 32'd15});
        start_q.push_back(cyc + 1);
        exp_q.push_back({1'b0, 32'd18});
        start_q.push_back(cyc + 35);
        @(negedge clk);
        check("hold_busy1", {63'd0, busy}, 64'd1);
        repeat (33) @(negedge clk);
        check("hold_gap", {63'd0, busy}, 64'd0);
        op_a = 32'd2;
        op_b = 32'd9;
        @(negedge clk);
        check("hold_busy2", {63'd0, busy}, 64'd1);
        start_mult = 1'b0;
        wait_done(1'b0);

        repeat (5) @(negedge clk);
        check("queue_drained", 64'(exp_q.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
